// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module     : opb_register_bank_ppc2simulink
// Description: OPB slave bank of NUM_REGS byte-writable 32-bit registers with
//              readback and per-register update strobes for Simulink fabric.
//              Optional macro OPB_REG_SHADOW_COMMIT_EN: shadow registers plus
//              a COMMIT register at index NUM_REGS for atomic multi-word loads.
// Revision   : 1.0 - initial release
// ============================================================================
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000500,
  parameter logic [31:0] C_HIGHADDR   = 32'h010005FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          NUM_REGS     = 4,
  parameter logic [31:0] RESET_VALUE  = 32'h0
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  output logic                         Sl_xferAck,
  output logic [32*NUM_REGS-1:0]       user_data_out,
  output logic [NUM_REGS-1:0]          user_wr_pulse
);

  localparam int C_IDX_W = C_OPB_AWIDTH - 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [C_IDX_W-1:0]   idx_q, idx_d;
  logic                 rnw_q, rnw_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          live_q [NUM_REGS];
  logic [31:0]          live_d [NUM_REGS];
  logic [NUM_REGS-1:0]  pulse_q, pulse_d;
`ifdef OPB_REG_SHADOW_COMMIT_EN
  localparam logic [C_IDX_W-1:0] C_COMMIT_IDX = C_IDX_W'(NUM_REGS);
  logic [31:0]          shadow_q [NUM_REGS];
  logic [31:0]          shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0]  dirty_q, dirty_d;
`endif

  logic [31:0]          w_offset;
  logic                 w_hit;
  logic                 w_ack;
  logic [31:0]          w_rd_data;
  logic                 w_unused;

  // BE[0] steers the most significant byte, so a [0:3] -> [3:0] copy lines
  // each enable up with user byte lane b = bits [8b+7:8b].
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_offset = 32'(OPB_ABus) - C_BASEADDR;
  assign w_hit    = OPB_select && (32'(OPB_ABus) >= C_BASEADDR) &&
                    (32'(OPB_ABus) <= C_HIGHADDR);
  assign w_ack    = (state_q == ST_ACK) && !OPB_Rst;
  assign w_unused = &{1'b0, OPB_seqAddr, w_offset[1:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rnw_d   = rnw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    live_d  = live_q;
    pulse_d = '0;
`ifdef OPB_REG_SHADOW_COMMIT_EN
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_hit) begin
          state_d = ST_ACK;
          idx_d   = w_offset[C_IDX_W+1:2];
          rnw_d   = OPB_RNW;
          be_d    = 4'(OPB_BE);
          wdata_d = 32'(OPB_DBus);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (!rnw_q) begin
`ifdef OPB_REG_SHADOW_COMMIT_EN
          for (int k = 0; k < NUM_REGS; k++) begin
            if (idx_q == C_IDX_W'(k)) begin
              shadow_d[k] = f_merge(shadow_q[k], wdata_q, be_q);
              dirty_d[k]  = 1'b1;
            end
          end
          if (idx_q == C_COMMIT_IDX) begin
            live_d  = shadow_q;
            pulse_d = dirty_q;
            dirty_d = '0;
          end
`else
          for (int k = 0; k < NUM_REGS; k++) begin
            if (idx_q == C_IDX_W'(k)) begin
              live_d[k]  = f_merge(live_q[k], wdata_q, be_q);
              pulse_d[k] = 1'b1;
            end
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rnw_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        live_q[k] <= RESET_VALUE;
      end
`ifdef OPB_REG_SHADOW_COMMIT_EN
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= RESET_VALUE;
      end
      dirty_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rnw_q   <= rnw_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      pulse_q <= pulse_d;
      live_q  <= live_d;
`ifdef OPB_REG_SHADOW_COMMIT_EN
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
`endif
    end
  end

  // Indices inside the address window but beyond the bank read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx_q == C_IDX_W'(k)) begin
`ifdef OPB_REG_SHADOW_COMMIT_EN
        w_rd_data = shadow_q[k];
`else
        w_rd_data = live_q[k];
`endif
      end
    end
`ifdef OPB_REG_SHADOW_COMMIT_EN
    if (idx_q == C_COMMIT_IDX) begin
      w_rd_data = {31'b0, |dirty_q};
    end
`endif
  end

  assign Sl_xferAck = w_ack;
  assign Sl_DBus    = (w_ack && rnw_q) ? C_OPB_DWIDTH'(w_rd_data) : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign user_wr_pulse = pulse_q;

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_user_out
      assign user_data_out[32*k +: 32] = live_q[k];
    end
  endgenerate

endmodule
`default_nettype wire
